// File: rtl/cfg_reg_arbiter_pkg.sv
// cfg_arb_pkg: shared constants for the configuration register arbiter.
// Contents:
//   CFG_NUM_REGS / CFG_ADDR_W / CFG_DATA_W : default bank geometry
//   ST_IDLE / ST_GRANT / ST_COMMIT         : FSM state encodings
//   REG_*                                  : register index names within the bank
package cfg_arb_pkg;

    localparam int CFG_NUM_REGS = 5;
    localparam int CFG_ADDR_W   = 7;
    localparam int CFG_DATA_W   = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam int REG_OUT_EN_LO = 0;
    localparam int REG_OUT_EN_HI = 1;
    localparam int REG_PWM_EN_LO = 2;
    localparam int REG_PWM_EN_HI = 3;
    localparam int REG_PWM_DUTY  = 4;

endpackage

// File: rtl/cfg_reg_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Ports:
//   req_i  in  NREQ   request vector
//   ptr_i  in  IDX_W  index with highest priority this round
//   win_o  out IDX_W  first set request scanning upward from ptr_i, wrapping
//   any_o  out 1      at least one request is set
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] win_o,
    output logic             any_o
);

    logic [IDX_W:0] s;

    assign any_o = |req_i;

    // Scan from lowest to highest priority so the last hit (closest to ptr_i) wins.
    always_comb begin
        win_o = '0;
        s     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            s = {1'b0, ptr_i} + (IDX_W + 1)'(i);
            if (s >= (IDX_W + 1)'(NREQ)) s = s - (IDX_W + 1)'(NREQ);
            if (req_i[s[IDX_W-1:0]]) win_o = s[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// cfg_reg_arbiter: round-robin write arbiter owning the PWM/IO configuration register bank.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   req_valid    NREQ          per-requester write request
//   req_addr     NREQ*ADDR_W   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data     NREQ*DATA_W   packed write data, same packing
//   req_ready    NREQ          one-cycle acknowledge to the granted requester
//   req_err      1             pulses with req_ready when the address is out of range
//   regs_o       NUM_REGS*DATA_W register bank, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe    NUM_REGS      pulses on the register updated this cycle
//   busy         1             high while a write is in GRANT or COMMIT
//   err_count    8             saturating rejected-write count
// Build option: define CFG_ARB_ERRCNT_EN to build the error counter; otherwise err_count is 0.
module cfg_reg_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = CFG_ADDR_W,
    parameter int DATA_W   = CFG_DATA_W,
    parameter int NUM_REGS = CFG_NUM_REGS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*DATA_W-1:0]     req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       req_err,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       busy,
    output logic [7:0]                 err_count
);

    localparam int IDX_W = $clog2(NREQ);

    logic [1:0]                 state_q, state_d;
    logic [IDX_W-1:0]           win_q, win_d, ptr_q, ptr_d, pick;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          data_q, data_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]        strobe_q, strobe_d;
    logic [NREQ-1:0]            ready_q, ready_d, pick_req;
    logic                       err_q, err_d, any;

    // In COMMIT the requester being acked still shows its old valid; hide it from arbitration.
    assign pick_req = (state_q == ST_COMMIT) ? (req_valid & ~(NREQ'(1) << win_q)) : req_valid;

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req_i (pick_req),
        .ptr_i (ptr_q),
        .win_o (pick),
        .any_o (any)
    );

    // Leaving GRANT performs the commit so its effects are visible throughout COMMIT.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ptr_d    = ptr_q;
        regs_d   = regs_q;
        ready_d  = '0;
        strobe_d = '0;
        err_d    = 1'b0;
        if (state_q == ST_GRANT) begin
            state_d = ST_COMMIT;
            ready_d = NREQ'(1) << win_q;
            ptr_d   = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
            err_d   = addr_q >= ADDR_W'(NUM_REGS);
            for (int k = 0; k < NUM_REGS; k++) begin
                if (addr_q == ADDR_W'(k)) begin
                    regs_d[k*DATA_W +: DATA_W] = data_q;
                    strobe_d[k]                = 1'b1;
                end
            end
        end else if (any) begin
            state_d = ST_GRANT;
            win_d   = pick;
            addr_d  = req_addr[pick*ADDR_W +: ADDR_W];
            data_d  = req_data[pick*DATA_W +: DATA_W];
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            ptr_q    <= '0;
            regs_q   <= '0;
            strobe_q <= '0;
            ready_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ptr_q    <= ptr_d;
            regs_q   <= regs_d;
            strobe_q <= strobe_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign req_err   = err_q;
    assign regs_o    = regs_q;
    assign wr_strobe = strobe_q;
    assign busy      = state_q != ST_IDLE;

`ifdef CFG_ARB_ERRCNT_EN
    logic [7:0] errcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) errcnt_q <= '0;
        else if (err_d && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
    end

    assign err_count = errcnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// tb_cfg_reg_arbiter: transaction-model checker plus directed scenarios for cfg_reg_arbiter.
module tb_cfg_reg_arbiter;

    localparam int NREQ     = 2;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 5;
`ifdef CFG_ARB_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NREQ-1:0]            req_valid = '0;
    logic [NREQ*ADDR_W-1:0]     req_addr = '0;
    logic [NREQ*DATA_W-1:0]     req_data = '0;
    logic [NREQ-1:0]            req_ready;
    logic                       req_err;
    logic [NUM_REGS*DATA_W-1:0] regs_o;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic                       busy;
    logic [7:0]                 err_count;

    int tests = 0;
    int fails = 0;

    cfg_reg_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .req_err   (req_err),
        .regs_o    (regs_o),
        .wr_strobe (wr_strobe),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a latched write (pend) commits on the next edge; the committed
    // requester (ack) is shown for one cycle and is excluded from the next pick.
    bit              m_pend;
    int              m_pw, m_ack, m_ptr, m_errcnt;
    int              m_pa, m_ca;
    logic [7:0]      m_pd;
    logic [7:0]      m_regs [NUM_REGS];

    task automatic m_reset();
        m_pend = 1'b0; m_pw = 0; m_ack = -1; m_ptr = 0; m_errcnt = 0; m_pa = 0; m_ca = 0; m_pd = '0;
        for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else if (m_pend) begin
                m_pend = 1'b0;
                m_ack  = m_pw;
                m_ca   = m_pa;
                if (m_pa < NUM_REGS) m_regs[m_pa] = m_pd;
                else if (ERRCNT && m_errcnt < 255) m_errcnt++;
                m_ptr = (m_pw + 1) % NREQ;
            end else begin
                int skip;
                skip  = m_ack;
                m_ack = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (!m_pend && req_valid[i] && i != skip) begin
                        m_pend = 1'b1;
                        m_pw   = i;
                        m_pa   = int'(req_addr[i*ADDR_W +: ADDR_W]);
                        m_pd   = req_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            logic [NREQ-1:0]            er;
            logic [NUM_REGS-1:0]        es;
            logic [NUM_REGS*DATA_W-1:0] eg;
            @(negedge clk);
            er = '0;
            es = '0;
            if (m_ack >= 0) er[m_ack] = 1'b1;
            if (m_ack >= 0 && m_ca < NUM_REGS) es[m_ca] = 1'b1;
            for (int k = 0; k < NUM_REGS; k++) eg[k*DATA_W +: DATA_W] = m_regs[k];
            chk("model_ready", req_ready, er);
            chk("model_err", req_err, m_ack >= 0 && m_ca >= NUM_REGS);
            chk("model_strobe", wr_strobe, es);
            chk("model_busy", busy, m_pend || m_ack >= 0);
            chk("model_regs", regs_o, eg);
            chk("model_errcnt", err_count, m_errcnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[i]                 = v;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    function automatic logic [DATA_W-1:0] reg_at(input int k);
        return regs_o[k*DATA_W +: DATA_W];
    endfunction

    initial begin
        logic [NREQ-1:0]            acks [4];
        logic [NUM_REGS*DATA_W-1:0] snap;
        int                         n;
        logic [7:0]                 d0, d1;

        set_req(0, 1'b1, 7'd1, 8'hEE);
        set_req(1, 1'b1, 7'd2, 8'hDD);
        repeat (3) step();
        chk("rst_regs", regs_o, '0);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_errcnt", err_count, 8'h00);
        req_valid = '0;
        rst_n = 1'b1;
        step();

        set_req(0, 1'b1, 7'd2, 8'hA5);
        step();
        chk("single_grant_busy", busy, 1'b1);
        chk("single_grant_ready", req_ready, 2'b00);
        step();
        chk("single_reg2", reg_at(2), 8'hA5);
        chk("single_strobe", wr_strobe, 5'b00100);
        chk("single_ready", req_ready, 2'b01);
        req_valid = '0;
        step();
        chk("single_ready_drop", req_ready, 2'b00);
        chk("single_idle", busy, 1'b0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(0, 1'b1, 7'd0, 8'h11);
        set_req(1, 1'b1, 7'd1, 8'h22);
        step();
        step();
        chk("cont_first_ready", req_ready, 2'b01);
        chk("cont_reg0", reg_at(0), 8'h11);
        chk("cont_reg1_pending", reg_at(1), 8'h00);
        req_valid[0] = 1'b0;
        step();
        chk("cont_gap_ready", req_ready, 2'b00);
        chk("cont_gap_busy", busy, 1'b1);
        step();
        chk("cont_second_ready", req_ready, 2'b10);
        chk("cont_reg1", reg_at(1), 8'h22);
        req_valid = '0;
        step();

        d0 = 8'h01;
        d1 = 8'h81;
        set_req(0, 1'b1, 7'd2, d0);
        set_req(1, 1'b1, 7'd3, d1);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (req_ready != '0 && n < 4) begin
                acks[n] = req_ready;
                n++;
            end
            if (req_ready[0]) begin d0++; set_req(0, 1'b1, 7'd2, d0); end
            if (req_ready[1]) begin d1++; set_req(1, 1'b1, 7'd3, d1); end
        end
        chk("fair_count", n, 4);
        chk("fair_ack0", acks[0], 2'b01);
        chk("fair_ack1", acks[1], 2'b10);
        chk("fair_ack2", acks[2], 2'b01);
        chk("fair_ack3", acks[3], 2'b10);
        chk("fair_reg2", reg_at(2), 8'h02);
        chk("fair_reg3", reg_at(3), 8'h82);
        req_valid = '0;
        step();

        snap = regs_o;
        set_req(1, 1'b1, 7'd5, 8'hFF);
        step();
        step();
        chk("oor_ready", req_ready, 2'b10);
        chk("oor_err", req_err, 1'b1);
        chk("oor_strobe", wr_strobe, 5'b00000);
        chk("oor_regs", regs_o, snap);
        chk("oor_errcnt", err_count, ERRCNT ? 8'd1 : 8'd0);
        req_valid = '0;
        step();
        chk("oor_err_drop", req_err, 1'b0);

        set_req(0, 1'b1, 7'd4, 8'h5A);
        step();
        step();
        chk("last_strobe", wr_strobe, 5'b10000);
        chk("last_reg4", reg_at(4), 8'h5A);
        req_valid = '0;
        step();

        set_req(0, 1'b1, 7'h44, 8'h99);
        step();
        step();
        chk("alias_err", req_err, 1'b1);
        chk("alias_ready", req_ready, 2'b01);
        chk("alias_reg4", reg_at(4), 8'h5A);
        req_valid = '0;
        step();

        set_req(0, 1'b1, 7'd1, 8'h77);
        step();
        req_valid = '0;
        step();
        chk("drop_reg1", reg_at(1), 8'h77);
        chk("drop_ready", req_ready, 2'b01);
        step();

        set_req(0, 1'b1, 7'd3, 8'h3C);
        step();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        step();
        chk("midrst_reg3", reg_at(3), 8'h00);
        chk("midrst_ready", req_ready, 2'b00);
        chk("midrst_strobe", wr_strobe, 5'b00000);
        rst_n = 1'b1;
        step();
        step();
        chk("midrst_after_ready", req_ready, 2'b00);
        chk("midrst_after_busy", busy, 1'b0);

        set_req(0, 1'b1, 7'h7F, 8'h00);
        repeat (800) step();
        chk("sat_errcnt", err_count, ERRCNT ? 8'hFF : 8'h00);
        req_valid = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
